// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Purpose  : Shares the unified memory data port between fetch and load/store
//            requesters; ARB_ROUND_ROBIN_EN selects round-robin tie-breaking.
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  instrReq,
  input  logic [ADDR_WIDTH-1:0] instrAddr,
  output logic                  instrAck,
  output logic [31:0]           instrData,
  input  logic                  dataReq,
  input  logic                  dataWe,
  input  logic [ADDR_WIDTH-1:0] dataAddr,
  input  logic [31:0]           dataIn,
  output logic                  dataAck,
  output logic [31:0]           dataOut,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memDIn,
  output logic                  memWe,
  input  logic [31:0]           memDOut
);

  localparam int unsigned c_cnt_w   = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic        c_owner_i = 1'b0;
  localparam logic        c_owner_d = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  owner_q, owner_d;
  logic [c_cnt_w-1:0]    cnt_q, cnt_d;
  logic [31:0]           instr_data_q, instr_data_d;
  logic [31:0]           data_out_q, data_out_d;
  logic                  w_any_req;
  logic                  w_grant_data;

  assign w_any_req = instrReq | dataReq;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  // On a tie the grant goes to whichever requester was not served last.
  assign w_grant_data = dataReq & (~instrReq | (last_owner_q == c_owner_i));

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == S_IDLE && w_any_req) begin
      last_owner_d = w_grant_data ? c_owner_d : c_owner_i;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      last_owner_q <= c_owner_i;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  assign w_grant_data = dataReq;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    instr_data_d = instr_data_q;
    data_out_d   = data_out_q;
    case (state_q)
      S_IDLE: begin
        if (w_any_req) begin
          owner_d = w_grant_data ? c_owner_d : c_owner_i;
          addr_d  = w_grant_data ? dataAddr : instrAddr;
          wdata_d = w_grant_data ? dataIn : 32'h0;
          we_d    = w_grant_data & dataWe;
          cnt_d   = c_cnt_w'(WAIT_CYCLES);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - c_cnt_w'(1);
        end else begin
          // Memory has not been written yet, so a store captures the old word.
          if (owner_q == c_owner_d) begin
            data_out_d = memDOut;
          end else begin
            instr_data_d = memDOut;
          end
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      we_q         <= 1'b0;
      owner_q      <= c_owner_i;
      cnt_q        <= '0;
      instr_data_q <= 32'h0;
      data_out_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      instr_data_q <= instr_data_d;
      data_out_q   <= data_out_d;
    end
  end

  assign instrAck  = (state_q == S_DONE) && (owner_q == c_owner_i);
  assign dataAck   = (state_q == S_DONE) && (owner_q == c_owner_d);
  assign memWe     = (state_q == S_DONE) && we_q;
  assign memAddr   = addr_q;
  assign memDIn    = wdata_q;
  assign instrData = instr_data_q;
  assign dataOut   = data_out_q;

endmodule
`default_nettype wire
